// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the pipeline front end
// (instruction width, major opcodes, default reset PC, fetch FSM states).
package cpu_pkg;

  localparam int          INSTR_W          = 32;
  localparam int unsigned RESET_PC_DEFAULT = 0;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instr} words with push, pop and flush.
// Flush wins over push and pop in the same cycle; storage itself is not reset.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 41
) (
  input  logic                         clka,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic                         valid,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & valid & ~flush;
  assign do_push = push & ~flush & ((count != CW'(DEPTH)) | do_pop);

  always_ff @(posedge clka) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: byte-serial instruction fetch into a word FIFO for decode.
// Optional IF_STATS_EN adds saturating fetched/flushed counters.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 9,
  parameter int unsigned RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clka,
  input  logic               rst_n,
  output logic               mem_rd,
  output logic [AW-1:0]      mem_addr,
  input  logic [7:0]         mem_rdata,
  input  logic               redirect_valid,
  input  logic [AW-1:0]      redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [AW-1:0]      out_pc
`ifdef IF_STATS_EN
  ,
  output logic [15:0]        stat_fetched,
  output logic [15:0]        stat_flushed
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int FW = AW + INSTR_W;

  fetch_state_e  state;
  fetch_state_e  state_nxt;
  logic [AW-1:0] fetch_pc;
  logic [1:0]    bcnt;
  logic [1:0]    inflight;
  logic [23:0]   asm_reg;
  logic          resp_pend;
  logic          resp_kill;
  logic [1:0]    rsp_idx_p1;
  logic [AW-1:0] rsp_pc_p1;

  logic          issue;
  logic          room;
  logic          pop_fire;
  logic          rsp_take;
  logic          push;
  logic [OW-1:0] occ;
  logic [AW-1:0] redir_pc_al;
  logic [CW-1:0] fifo_count;
  logic          fifo_valid;
  logic [FW-1:0] fifo_head;
  logic [FW-1:0] push_data;
  logic          unused_redir_lsb;

  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign redir_pc_al      = {redirect_pc[AW-1:2], 2'b00};

  // Occupancy counts words still being assembled so a started word always has a slot.
  assign pop_fire = fifo_valid & out_ready & ~redirect_valid;
  assign occ      = OW'(fifo_count) + OW'(inflight) - OW'(pop_fire);
  assign room     = occ < OW'(DEPTH);

  assign rsp_take  = resp_pend & ~resp_kill & ~redirect_valid;
  assign push      = rsp_take & (rsp_idx_p1 == 2'd3);
  assign push_data = {rsp_pc_p1, mem_rdata, asm_reg};

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) state <= S_REQ;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid)                 state_nxt = S_REQ;
    else if ((bcnt == 2'd0) && !room)   state_nxt = S_HOLD;
    else                                state_nxt = S_REQ;
  end

  always_comb begin
    issue = 1'b0;
    if (redirect_valid) begin
      issue = 1'b1;
    end else begin
      case (state)
        S_REQ:   issue = (bcnt != 2'd0) || room;
        S_HOLD:  issue = room;
        default: issue = 1'b0;
      endcase
    end
  end

  // Request stage: registered byte request and PC bookkeeping.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= AW'(RESET_PC);
      bcnt     <= 2'd0;
      inflight <= 2'd0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redir_pc_al;
      bcnt     <= 2'd1;
      inflight <= 2'd1;
      mem_rd   <= 1'b1;
      mem_addr <= redir_pc_al;
    end else begin
      mem_rd   <= issue;
      inflight <= inflight + 2'(issue && (bcnt == 2'd0)) - 2'(push);
      if (issue) begin
        mem_addr <= fetch_pc + AW'(bcnt);
        bcnt     <= bcnt + 2'd1;
        if (bcnt == 2'd3) fetch_pc <= fetch_pc + AW'(4);
      end
    end
  end

  // Response stage: byte returns one cycle after its request.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      resp_pend <= 1'b0;
      resp_kill <= 1'b0;
    end else begin
      resp_pend <= mem_rd;
      resp_kill <= redirect_valid;
    end
  end

  always_ff @(posedge clka) begin
    rsp_idx_p1 <= mem_addr[1:0];
    rsp_pc_p1  <= {mem_addr[AW-1:2], 2'b00};
    if (rsp_take) begin
      case (rsp_idx_p1)
        2'd0:    asm_reg[7:0]   <= mem_rdata;
        2'd1:    asm_reg[15:8]  <= mem_rdata;
        2'd2:    asm_reg[23:16] <= mem_rdata;
        default: ;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clka      (clka),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop_fire),
    .flush     (redirect_valid),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign out_valid = fifo_valid;
  assign out_instr = fifo_valid ? fifo_head[INSTR_W-1:0] : '0;
  assign out_pc    = fifo_valid ? fifo_head[FW-1:INSTR_W] : '0;

`ifdef IF_STATS_EN
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched <= 16'd0;
      stat_flushed <= 16'd0;
    end else begin
      if (push) stat_fetched <= sat_add(stat_fetched, 16'd1);
      if (redirect_valid)
        stat_flushed <= sat_add(stat_flushed, 16'(fifo_count) + 16'(inflight != 2'd0));
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed scenarios plus randomized ready/redirect traffic
// checked against a word-level in-order fetch model over a byte RAM.
module tb_inst_fetch_unit;

  logic        clka;
  logic        rst_n;
  logic        mem_rd;
  logic [8:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [8:0]  out_pc;
`ifdef IF_STATS_EN
  logic [15:0] stat_fetched;
  logic [15:0] stat_flushed;
`endif

  logic [7:0]  ram [512];
  int          n_tests;
  int          n_fail;

  inst_fetch_unit #(.DEPTH(4), .AW(9), .RESET_PC(0)) dut (
    .clka           (clka),
    .rst_n          (rst_n),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef IF_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_flushed   (stat_flushed)
`endif
  );

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  // Byte RAM: data for a request appears the following cycle; noise otherwise.
  always_ff @(posedge clka) begin
    mem_rdata <= mem_rd ? ram[mem_addr] : 8'($urandom);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [8:0] pc);
    logic [31:0] w;
    logic [8:0]  a;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      a = pc + 9'(k);
      w[8*k +: 8] = ram[a];
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic fill_ram();
    for (int i = 0; i < 512; i++) ram[i] = 8'($urandom);
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    rst_n          = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (out_valid) found = 1'b1;
      else tick();
    end
    chk(tag, 64'(found), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    int          nreq;
    int          npop;
    bit          after_redir;
    logic [8:0]  exp_pc;
    logic [8:0]  exp_list [3];

    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    #2;

    // Reset values and first-word latency.
    fill_ram();
    ram[0] = 8'h20; ram[1] = 8'h10; ram[2] = 8'h01; ram[3] = 8'h00;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_instr", 64'(out_instr), 64'(0));
    chk("rst_out_pc",    64'(out_pc),    64'(0));
    chk("rst_mem_rd",    64'(mem_rd),    64'(0));
    chk("rst_mem_addr",  64'(mem_addr),  64'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("t1_first_rd",   64'(mem_rd),   64'(1));
    chk("t1_first_addr", 64'(mem_addr), 64'(0));
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k <= 3) chk("t1_seq_addr", 64'(mem_addr), 64'(k));
      if (k == 4) chk("t1_not_yet_valid", 64'(out_valid), 64'(0));
      if (k == 5) begin
        chk("t1_valid", 64'(out_valid), 64'(1));
        chk("t1_instr", 64'(out_instr), 64'(32'h0001_1020));
        chk("t1_pc",    64'(out_pc),    64'(0));
`ifdef IF_STATS_EN
        chk("t1_stat_fetched", 64'(stat_fetched), 64'(1));
`endif
      end
    end

    // Decode stalled: exactly DEPTH words buffered, then drained back-to-back.
    fill_ram();
    do_reset();
    nreq = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_rd) nreq++;
    end
    chk("t2_req_count", 64'(nreq),      64'(16));
    chk("t2_rd_low",    64'(mem_rd),    64'(0));
    chk("t2_valid",     64'(out_valid), 64'(1));
    chk("t2_head_pc",   64'(out_pc),    64'(0));
    chk("t2_head_instr", 64'(out_instr), 64'(exp_word(9'h000)));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_valid", 64'(out_valid), 64'(1));
      chk("t2_drain_pc",    64'(out_pc),    64'(4 * i));
      chk("t2_drain_instr", 64'(out_instr), 64'(exp_word(9'(4 * i))));
      tick();
    end

    // Redirect while byte 2 of the third word is in flight (FIFO holds two).
    fill_ram();
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (mem_rd && mem_addr == 9'h00A) found = 1'b1;
    end
    chk("t3_reach_byte2", 64'(found), 64'(1));
    chk("t3_pre_valid", 64'(out_valid), 64'(1));
    chk("t3_pre_pc",    64'(out_pc),    64'(0));
    redirect_valid = 1'b1;
    redirect_pc    = 9'h044;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    chk("t3_flush_valid", 64'(out_valid), 64'(0));
    chk("t3_target_rd",   64'(mem_rd),    64'(1));
    chk("t3_target_addr", 64'(mem_addr),  64'(9'h044));
`ifdef IF_STATS_EN
    chk("t3_stat_flushed", 64'(stat_flushed), 64'(3));
`endif
    for (int k = 2; k <= 6; k++) begin
      tick();
      if (k == 5) chk("t3_not_yet_valid", 64'(out_valid), 64'(0));
      if (k == 6) begin
        chk("t3_valid", 64'(out_valid), 64'(1));
        chk("t3_pc",    64'(out_pc),    64'(9'h044));
        chk("t3_instr", 64'(out_instr), 64'(exp_word(9'h044)));
      end
    end

    // Unaligned redirect target is forced to a word boundary.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 9'h047;
    tick();
    redirect_valid = 1'b0;
    chk("t4_addr", 64'(mem_addr), 64'(9'h044));
    wait_valid("t4_wait", 12);
    chk("t4_pc",    64'(out_pc),    64'(9'h044));
    chk("t4_instr", 64'(out_instr), 64'(exp_word(9'h044)));

    // Sequential fetch across the top of the address space.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 9'h1F8;
    tick();
    redirect_valid = 1'b0;
    exp_list[0] = 9'h1F8; exp_list[1] = 9'h1FC; exp_list[2] = 9'h000;
    for (int i = 0; i < 3; i++) begin
      wait_valid("t5_wait", 12);
      chk("t5_pc",    64'(out_pc),    64'(exp_list[i]));
      chk("t5_instr", 64'(out_instr), 64'(exp_word(exp_list[i])));
      tick();
    end

    // Redirect and pop together on a full FIFO, then asynchronous reset mid-word.
    fill_ram();
    do_reset();
    for (int i = 0; i < 30; i++) tick();
    chk("t6_full_valid", 64'(out_valid), 64'(1));
    chk("t6_full_rd",    64'(mem_rd),    64'(0));
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 9'h100;
    tick();
    redirect_valid = 1'b0;
    chk("t6_empty", 64'(out_valid), 64'(0));
`ifdef IF_STATS_EN
    chk("t6_stat_flushed", 64'(stat_flushed), 64'(4));
`endif
    wait_valid("t6_wait", 12);
    chk("t6_no_dup_pc", 64'(out_pc),    64'(9'h100));
    chk("t6_instr",     64'(out_instr), 64'(exp_word(9'h100)));
    out_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (mem_rd && mem_addr[1:0] == 2'd1 && out_valid) found = 1'b1;
    end
    chk("t6_midword", 64'(found), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_valid", 64'(out_valid), 64'(0));
    chk("t6_arst_instr", 64'(out_instr), 64'(0));
    chk("t6_arst_pc",    64'(out_pc),    64'(0));
    chk("t6_arst_rd",    64'(mem_rd),    64'(0));
    chk("t6_arst_addr",  64'(mem_addr),  64'(0));
    tick();

    // Randomized ready and redirects against an in-order word model.
    fill_ram();
    do_reset();
    exp_pc = 9'h000;
    npop = 0;
    after_redir = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (after_redir) begin
        chk("rnd_redir_valid", 64'(out_valid), 64'(0));
        chk("rnd_redir_addr",  64'(mem_addr),  64'(exp_pc));
        after_redir = 1'b0;
      end
      if (out_valid) chk("rnd_head_pc", 64'(out_pc), 64'(exp_pc));
      out_ready      = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 64) == 0;
      redirect_pc    = 9'($urandom);
      if (redirect_valid) begin
        exp_pc = {redirect_pc[8:2], 2'b00};
        after_redir = 1'b1;
      end else if (out_valid && out_ready) begin
        chk("rnd_instr", 64'(out_instr), 64'(exp_word(exp_pc)));
        exp_pc = exp_pc + 9'd4;
        npop++;
      end
      tick();
    end
    redirect_valid = 1'b0;
    chk("rnd_progress", 64'(npop >= 200), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
